bubble_sort_ctrl: RTL and testbench

- Sequencer that owns one `comparator` instance and time-shares it to sort a block of N unsigned W-bit values, using bubble sort with early exit.
- Operation is load, sort, drain, with valid/ready handshakes on both sides.
- It sits between a serial producer and a serial consumer as a small sort/rank engine.

---
 rtl/bubble_sort_ctrl_pkg.sv | 21 ++
 rtl/bubble_sort_ctrl_if.sv | 34 +++
 rtl/bubble_sort_ctrl_comparator.sv | 22 ++
 rtl/bubble_sort_ctrl.sv | 158 +++++++++++++++
 tb/tb_bubble_sort_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/bubble_sort_ctrl_pkg.sv
// bubble_sort_ctrl_pkg
// Shared definitions for the bubble sort sequencer: default block geometry
// and the controller state encoding.
//   N_DEF     - entries per block
//   W_DEF     - data width (must match the shared comparator)
//   IDX_W_DEF - index width, clog2(N)
//   CNT_W_DEF - compare counter width, holds N*(N-1)/2
package bubble_sort_ctrl_pkg;

  localparam int N_DEF     = 8;
  localparam int W_DEF     = 3;
  localparam int IDX_W_DEF = 3;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// bubble_sort_ctrl_if
// Producer/consumer handshake bundle plus status for the sort engine.
//   in_valid/in_ready/in_data    - serial load side
//   out_valid/out_ready/out_data - serial drain side, smallest value first
//   busy                         - high while sorting
//   cmp_count                    - compares issued in the current/last sort
// Modports: slave = the sort engine, master = the surrounding producer/consumer.
interface bubble_sort_ctrl_if
  import bubble_sort_ctrl_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             busy;
  logic [CNT_W-1:0] cmp_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, cmp_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, cmp_count
  );

endinterface

// File: rtl/bubble_sort_ctrl_comparator.sv
// comparator
// Unsigned magnitude comparator; the single compare resource that the sort
// sequencer time-shares.
//   a, b  - unsigned W-bit operands
//   equal - a == b
//   gt    - a > b
//   lt    - a < b
module comparator #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         equal,
  output logic         gt,
  output logic         lt
);

  assign equal = (a == b);
  assign gt    = (a > b);
  assign lt    = (a < b);

endmodule

// File: rtl/bubble_sort_ctrl.sv
// bubble_sort_ctrl
// Load / sort / drain engine for blocks of N unsigned W-bit values. The block
// is loaded serially, sorted in place with bubble sort (one compare per cycle
// through a single shared comparator, early exit on a pass with no swaps),
// then drained serially smallest first.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, aborts any block in flight
//   bus   - slave side of bubble_sort_ctrl_if (handshakes, busy, cmp_count)
module bubble_sort_ctrl
  import bubble_sort_ctrl_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  bubble_sort_ctrl_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_wrPtr;
  logic [IDX_W-1:0] r_rdPtr;
  logic [IDX_W-1:0] r_j;
  logic [IDX_W-1:0] r_limit;
  logic             r_swapped;
  logic [CNT_W-1:0] r_cmpCount;
  logic             r_inReady;
  logic             r_outValid;
  logic             r_busy;
  logic [W-1:0]     r_mem [N];

  logic [IDX_W-1:0] w_jNext;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic             w_eq;
  logic             w_gt;
  logic             w_lt;
  logic             w_swap;
  logic             w_swappedNow;
  logic             w_endPass;
  logic             w_inFire;
  logic             w_outFire;

  // j never exceeds N-2 during SORT, so j+1 stays inside the array.
  assign w_jNext = r_j + 1'b1;
  assign w_a     = r_mem[r_j];
  assign w_b     = r_mem[w_jNext];

  comparator #(.W(W)) u_cmp (
    .a     (w_a),
    .b     (w_b),
    .equal (w_eq),
    .gt    (w_gt),
    .lt    (w_lt)
  );

  // Only a strict greater-than swaps; ties keep their order so the sort is stable.
  assign w_swap       = (r_state == S_SORT) & w_gt & ~(w_eq | w_lt);
  assign w_swappedNow = r_swapped | w_swap;
  assign w_endPass    = (r_j == r_limit - 1'b1);
  assign w_inFire     = r_inReady & bus.in_valid;
  assign w_outFire    = r_outValid & bus.out_ready;

  // Register array carries no reset; its contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (w_inFire) begin
      r_mem[r_wrPtr] <= bus.in_data;
    end
    if (w_swap) begin
      r_mem[r_j]     <= w_b;
      r_mem[w_jNext] <= w_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LOAD;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_j        <= '0;
      r_limit    <= LAST_IDX;
      r_swapped  <= 1'b0;
      r_cmpCount <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_inFire) begin
            if (r_wrPtr == LAST_IDX) begin
              r_state    <= S_SORT;
              r_wrPtr    <= '0;
              r_j        <= '0;
              r_limit    <= LAST_IDX;
              r_swapped  <= 1'b0;
              r_cmpCount <= '0;
              r_inReady  <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_wrPtr <= r_wrPtr + 1'b1;
            end
          end
        end

        S_SORT: begin
          r_cmpCount <= r_cmpCount + 1'b1;
          if (!w_endPass) begin
            r_j       <= w_jNext;
            r_swapped <= w_swappedNow;
          end else if (!w_swappedNow || r_limit == IDX_W'(1)) begin
            // A clean pass (or the final one-compare pass) means the block is sorted.
            r_state    <= S_DRAIN;
            r_rdPtr    <= '0;
            r_busy     <= 1'b0;
            r_outValid <= 1'b1;
          end else begin
            r_limit   <= r_limit - 1'b1;
            r_j       <= '0;
            r_swapped <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (w_outFire) begin
            if (r_rdPtr == LAST_IDX) begin
              r_state    <= S_LOAD;
              r_rdPtr    <= '0;
              r_outValid <= 1'b0;
              r_inReady  <= 1'b1;
            end else begin
              r_rdPtr <= r_rdPtr + 1'b1;
            end
          end
        end

        default: begin
          r_state    <= S_LOAD;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.busy      = r_busy;
  assign bus.cmp_count = r_cmpCount;
  // Gated so out_data reads 0 outside DRAIN, including straight after reset.
  assign bus.out_data  = r_outValid ? r_mem[r_rdPtr] : '0;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// tb_bubble_sort_ctrl
// Directed, table-driven bench for bubble_sort_ctrl: loads blocks, measures
// sort time and compare count, drains and compares against hand-sorted
// blocks, plus backpressure and mid-sort reset sequences.
module tb_bubble_sort_ctrl;

  // Packed block: element i lives at bits [3*i +: 3], so literals below are
  // written last element first.
  typedef struct packed {
    logic [7:0][2:0] din;
    logic [7:0][2:0] dout;
    int              expBusy;
    int              expCmp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bubble_sort_ctrl_if #(.W(3), .CNT_W(6)) bus ();

  bubble_sort_ctrl #(.N(8), .W(3), .IDX_W(3), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Called on a negedge in LOAD; returns on the negedge of the first SORT cycle.
  task automatic loadBlock(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      checkOutput("load_in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = v.din[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Counts SORT cycles (busy high), up to maxCycles.
  task automatic waitSort(input bit stress, input int maxCycles, output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < maxCycles) begin
      checkOutput("sort_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("sort_out_valid", 32'(bus.out_valid), 32'd0);
      if (stress) begin
        bus.in_valid = n[0];
        bus.in_data  = 3'd7;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit stress);
    int          n;
    int          idx;
    logic        rdy;
    logic [3:0]  pattern;
    pattern = 4'b1001;
    loadBlock(v);
    waitSort(stress, 200, n);
    checkOutput("sort_timeout", 32'(n < 200), 32'd1);
    if (v.expBusy >= 0) checkOutput("busy_cycles", 32'(n), 32'(v.expBusy));
    else checkOutput("busy_in_range", 32'(n >= 7 && n <= 28), 32'd1);
    if (v.expCmp >= 0) checkOutput("cmp_count", 32'(bus.cmp_count), 32'(v.expCmp));
    else checkOutput("cmp_count_le_28", 32'(bus.cmp_count <= 6'd28), 32'd1);
    idx = 0;
    for (int c = 0; c < 64 && idx < 8; c++) begin
      checkOutput("drain_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("drain_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("drain_data", 32'(bus.out_data), 32'(v.dout[idx]));
      rdy = stress ? pattern[c % 4] : 1'b1;
      bus.out_ready = rdy;
      if (stress) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 3'd0;
      end
      @(negedge clk);
      if (rdy) idx++;
    end
    checkOutput("drain_count", 32'(idx), 32'd8);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checkOutput("post_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("post_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    vec_t vecs[4];
    vec_t stressVec;
    vec_t freshVec;
    int   n;

    // 5,3,7,0,6,1,2,4 -> 0..7
    vecs[0] = '{din: {3'd4,3'd2,3'd1,3'd6,3'd0,3'd7,3'd3,3'd5},
                dout: {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, expBusy: -1, expCmp: -1};
    // already sorted 0..7
    vecs[1] = '{din: {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0},
                dout: {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, expBusy: 7, expCmp: 7};
    // reverse 7..0
    vecs[2] = '{din: {3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7},
                dout: {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, expBusy: 28, expCmp: 28};
    // 3,3,1,3,1,0,0,7 -> 0,0,1,1,3,3,3,7
    vecs[3] = '{din: {3'd7,3'd0,3'd0,3'd1,3'd3,3'd1,3'd3,3'd3},
                dout: {3'd7,3'd3,3'd3,3'd3,3'd1,3'd1,3'd0,3'd0}, expBusy: -1, expCmp: -1};
    // 2,6,4,0,7,1,5,3 -> 0..7 under backpressure
    stressVec = '{din: {3'd3,3'd5,3'd1,3'd7,3'd0,3'd4,3'd6,3'd2},
                  dout: {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, expBusy: -1, expCmp: -1};
    // 4,4,2,6,1,0,5,3 -> 0,1,2,3,4,4,5,6 after the mid-sort reset
    freshVec = '{din: {3'd3,3'd5,3'd0,3'd1,3'd6,3'd2,3'd4,3'd4},
                 dout: {3'd6,3'd5,3'd4,3'd4,3'd3,3'd2,3'd1,3'd0}, expBusy: -1, expCmp: -1};

    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_cmp_count", 32'(bus.cmp_count), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i], 1'b0);
    end

    $display("[TB] backpressure sequence");
    applyStimulus(stressVec, 1'b1);

    $display("[TB] reset during sort");
    loadBlock(vecs[2]);
    waitSort(1'b0, 10, n);
    checkOutput("mid_sort_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_cmp_count", 32'(bus.cmp_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resume_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("resume_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("resume_cmp_count", 32'(bus.cmp_count), 32'd0);
    applyStimulus(freshVec, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
